// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the KLP32 multi-cycle controller: opcodes, immediate
// formats, ALU operations, mux selects, FSM states and instruction classes.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_ALU   = 2'b01;
  localparam logic [1:0] PC_JALR  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_NOP, CL_ILL
  } iclass_t;

  function automatic iclass_t classify(input logic [6:0] op);
    case (op)
      OP_OP:               return CL_OP;
      OP_OPIMM:            return CL_OPIMM;
      OP_LOAD:             return CL_LOAD;
      OP_STORE:            return CL_STORE;
      OP_BRANCH:           return CL_BRANCH;
      OP_JAL:              return CL_JAL;
      OP_JALR:             return CL_JALR;
      OP_LUI:              return CL_LUI;
      OP_AUIPC:            return CL_AUIPC;
      OP_FENCE, OP_SYSTEM: return CL_NOP;
      default:             return CL_ILL;
    endcase
  endfunction

  // R-type, NOP and illegal classes carry no immediate; I-format keeps them deterministic.
  function automatic logic [2:0] imm_fmt(input iclass_t c);
    case (c)
      CL_STORE:          return IMM_S;
      CL_BRANCH:         return IMM_B;
      CL_LUI, CL_AUIPC:  return IMM_U;
      CL_JAL:            return IMM_J;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_dec.sv
// ALU operation decode from opcode/funct3/funct7_5. Address, link and branch
// target computations all reduce to an add.
module rv32_alu_dec
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_OP, OP_OPIMM: begin
        case (funct3)
          3'b000: alu_op = (opcode == OP_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_op = ALU_SLL;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_op = ALU_OR;
          default: alu_op = ALU_AND;
        endcase
      end
      OP_LUI:  alu_op = ALU_PASSB;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing and the
// datapath select/enable lines. One instruction in flight at a time.
module rv32_mc_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter logic [1:0] RESET_PC_SEL = 2'b00,
  parameter int         IMM_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [IMM_W-1:0] imm_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [3:0]       alu_op,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [2:0]       state_o
);

  state_t     state;
  logic       ill_q;
  iclass_t    cls_d, cls_q;
  logic [2:0] imm_d, imm_q, imm_cur;
  logic [3:0] aop_d, aop_q;

  rv32_alu_dec u_alu_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (aop_d)
  );

  assign cls_d = classify(opcode);
  assign imm_d = imm_fmt(cls_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ill_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   state <= ST_FETCH;
        ST_FETCH:  if (imem_rdy) state <= ST_DECODE;
        ST_DECODE: begin
          if (cls_d == CL_ILL) begin
            state <= ST_TRAP;
            ill_q <= 1'b1;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CL_LOAD, CL_STORE:  state <= ST_MEM;
            CL_BRANCH, CL_NOP:  state <= ST_FETCH;
            default:            state <= ST_WB;
          endcase
        end
        ST_MEM:    if (dmem_rdy) state <= (cls_q == CL_LOAD) ? ST_WB : ST_FETCH;
        ST_WB:     state <= ST_FETCH;
        ST_TRAP:   state <= ST_TRAP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Decode results are frozen at DECODE exit so selects stay stable even if IR changes.
  always_ff @(posedge clk) begin
    if (state == ST_DECODE) begin
      cls_q <= cls_d;
      imm_q <= imm_d;
      aop_q <= aop_d;
    end
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    imm_cur   = IMM_I;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = ALU_ADD;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    case (state)
      ST_IDLE: pc_sel = RESET_PC_SEL;
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_rdy;
        pc_we    = imem_rdy;
      end
      ST_DECODE: begin
        imm_cur = imm_d;
        alu_op  = aop_d;
      end
      ST_EXEC, ST_MEM, ST_WB: begin
        imm_cur   = imm_q;
        alu_op    = aop_q;
        alu_a_sel = (cls_q == CL_AUIPC) || (cls_q == CL_BRANCH) || (cls_q == CL_JAL);
        // Branch target PC+imm is formed by the ALU as well.
        alu_b_sel = !((cls_q == CL_OP) || (cls_q == CL_NOP) || (cls_q == CL_ILL));
        if (state == ST_EXEC) begin
          case (cls_q)
            CL_BRANCH: begin pc_we = br_taken; pc_sel = PC_ALU;  end
            CL_JAL:    begin pc_we = 1'b1;     pc_sel = PC_ALU;  end
            CL_JALR:   begin pc_we = 1'b1;     pc_sel = PC_JALR; end
            default:   ;
          endcase
        end
        if (state == ST_MEM) begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CL_STORE);
        end
        if (state == ST_WB) begin
          reg_we = 1'b1;
          if (cls_q == CL_LOAD)
            wb_sel = WB_LOAD;
          else if ((cls_q == CL_JAL) || (cls_q == CL_JALR))
            wb_sel = WB_PC4;
        end
      end
      default: ;
    endcase
  end

  assign imm_sel = IMM_W'(imm_cur);
  assign illegal = ill_q;
  assign state_o = state;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Directed bench for rv32_mc_ctrl: builds an expected per-cycle trace from the
// instruction-level behaviour and compares every output on every cycle.
module tb_rv32_mc_ctrl;
  import rv32_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       imem_rdy = 1'b0, dmem_rdy = 1'b0, br_taken = 1'b0;
  logic       imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel;
  logic       dmem_req, dmem_we, reg_we, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] imm_sel, state_o;
  logic [3:0] alu_op;

  rv32_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .br_taken(br_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .imm_sel(imm_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel),
    .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_NOP, K_ILL} kind_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic f7;
    logic rstn, irdy, drdy, brt;
    logic [2:0] st; logic imem_req, ir_we, pc_we; logic [1:0] pc_sel;
    logic [2:0] imm; logic a, b; logic [3:0] aop;
    logic dreq, dwe, rwe; logic [1:0] wb; logic ill;
  } cyc_t;

  cyc_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] fmt_of(input kind_t k);
    case (k)
      K_ST:           return 3'b001;
      K_BR:           return 3'b010;
      K_LUI, K_AUIPC: return 3'b011;
      K_JAL:          return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  task automatic add_reset(input int n_low);
    cyc_t r;
    r = '{default: '0};
    for (int i = 0; i < n_low; i++) q.push_back(r);
    r.rstn = 1'b1;
    q.push_back(r);
  endtask

  // Expected trace of one instruction: iw fetch waits, dw memory waits.
  task automatic add_instr(input kind_t k, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int iw, input int dw, input logic brt,
                           input logic [3:0] aop, input int trap_n);
    cyc_t r;
    r = '{default: '0};
    r.op = op; r.f3 = f3; r.f7 = f7; r.rstn = 1'b1; r.brt = brt;
    r.st = 3'd1; r.imem_req = 1'b1;
    for (int i = 0; i < iw; i++) q.push_back(r);
    r.irdy = 1'b1; r.ir_we = 1'b1; r.pc_we = 1'b1;
    q.push_back(r);
    r.irdy = 1'b0; r.ir_we = 1'b0; r.pc_we = 1'b0; r.imem_req = 1'b0;
    r.st = 3'd2; r.imm = fmt_of(k); r.aop = aop;
    q.push_back(r);
    if (k == K_ILL) begin
      r.st = 3'd6; r.imm = 3'b000; r.aop = 4'd0; r.ill = 1'b1;
      for (int i = 0; i < trap_n; i++) q.push_back(r);
      return;
    end
    r.st = 3'd3;
    r.a = (k == K_AUIPC) || (k == K_BR) || (k == K_JAL);
    r.b = !((k == K_R) || (k == K_NOP));
    if (k == K_BR)   begin r.pc_we = brt;  r.pc_sel = 2'b01; end
    if (k == K_JAL)  begin r.pc_we = 1'b1; r.pc_sel = 2'b01; end
    if (k == K_JALR) begin r.pc_we = 1'b1; r.pc_sel = 2'b10; end
    q.push_back(r);
    r.pc_we = 1'b0; r.pc_sel = 2'b00;
    if (k == K_LD || k == K_ST) begin
      r.st = 3'd4; r.dreq = 1'b1; r.dwe = (k == K_ST);
      for (int i = 0; i < dw; i++) q.push_back(r);
      r.drdy = 1'b1;
      q.push_back(r);
      r.drdy = 1'b0; r.dreq = 1'b0; r.dwe = 1'b0;
    end
    if (k != K_ST && k != K_BR && k != K_NOP) begin
      r.st = 3'd5; r.rwe = 1'b1;
      r.wb = (k == K_LD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
      q.push_back(r);
    end
  endtask

  initial begin
    cyc_t r;
    int n0;
    add_reset(2);
    n0 = q.size(); add_instr(K_I, 7'b0010011, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    chk("len_addi", q.size() - n0, 4);
    n0 = q.size(); add_instr(K_ST, 7'b0100011, 3'b010, 1'b0, 0, 3, 1'b0, ALU_ADD, 0);
    chk("len_sw_wait3", q.size() - n0, 7);
    n0 = q.size(); add_instr(K_BR, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, ALU_ADD, 0);
    chk("len_beq_taken", q.size() - n0, 3);
    add_instr(K_BR,  7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    add_instr(K_LUI, 7'b0110111, 3'b000, 1'b0, 0, 0, 1'b0, ALU_PASSB, 0);
    n0 = q.size(); add_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    chk("len_jal", q.size() - n0, 4);
    add_instr(K_R,    7'b0110011, 3'b000, 1'b1, 2, 0, 1'b0, ALU_SUB, 0);
    add_instr(K_R,    7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    add_instr(K_I,    7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, ALU_ADD, 0);
    add_instr(K_I,    7'b0010011, 3'b101, 1'b1, 0, 0, 1'b0, ALU_SRA, 0);
    add_instr(K_I,    7'b0010011, 3'b101, 1'b0, 0, 0, 1'b0, ALU_SRL, 0);
    add_instr(K_R,    7'b0110011, 3'b100, 1'b1, 0, 0, 1'b0, ALU_XOR, 0);
    add_instr(K_R,    7'b0110011, 3'b011, 1'b0, 0, 0, 1'b0, ALU_SLTU, 0);
    add_instr(K_I,    7'b0010011, 3'b111, 1'b0, 1, 0, 1'b0, ALU_AND, 0);
    add_instr(K_JALR, 7'b1100111, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    add_instr(K_AUIPC,7'b0010111, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    n0 = q.size(); add_instr(K_NOP, 7'b0001111, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    chk("len_fence", q.size() - n0, 3);
    add_instr(K_NOP,  7'b1110011, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    n0 = q.size(); add_instr(K_LD, 7'b0000011, 3'b010, 1'b0, 0, 0, 1'b0, ALU_ADD, 0);
    chk("len_lw", q.size() - n0, 5);
    add_instr(K_ILL,  7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0, ALU_ADD, 4);
    add_reset(2);
    // lw cut off two cycles into a stalled MEM by a reset pulse
    add_instr(K_LD,   7'b0000011, 3'b010, 1'b0, 0, 5, 1'b0, ALU_ADD, 0);
    for (int i = 0; i < 5; i++) void'(q.pop_back());
    add_reset(1);
    add_instr(K_I,    7'b0010011, 3'b110, 1'b0, 0, 0, 1'b0, ALU_OR, 0);

    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      rst_n = r.rstn; opcode = r.op; funct3 = r.f3; funct7_5 = r.f7;
      imem_rdy = r.irdy; dmem_rdy = r.drdy; br_taken = r.brt;
      #1;
      chk("state_o",   state_o,   r.st);
      chk("imem_req",  imem_req,  r.imem_req);
      chk("ir_we",     ir_we,     r.ir_we);
      chk("pc_we",     pc_we,     r.pc_we);
      chk("pc_sel",    pc_sel,    r.pc_sel);
      chk("imm_sel",   imm_sel,   r.imm);
      chk("alu_a_sel", alu_a_sel, r.a);
      chk("alu_b_sel", alu_b_sel, r.b);
      chk("alu_op",    alu_op,    r.aop);
      chk("dmem_req",  dmem_req,  r.dreq);
      chk("dmem_we",   dmem_we,   r.dwe);
      chk("reg_we",    reg_we,    r.rwe);
      chk("wb_sel",    wb_sel,    r.wb);
      chk("illegal",   illegal,   r.ill);
      cyc++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
